regex_cpu_memory_arbiter: RTL and testbench

REGEX_CPU_MEMORY_ARBITER -- requirements
Module: regex_cpu_memory_arbiter

---
 rtl/regex_cpu_memory_arbiter_pkg.sv | 16 +
 rtl/regex_cpu_memory_arbiter_rr_arbiter.sv | 23 ++
 rtl/regex_cpu_memory_arbiter.sv | 117 +++++++++++
 tb/tb_regex_cpu_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regex_cpu_memory_arbiter_pkg.sv
// Shared constants, types and helpers for the regex CPU instruction-memory arbiter.
package regex_cpu_memory_arbiter_pkg;

    localparam int CONFLICT_W = 32;
    localparam int MAX_PORTS  = 16;

    typedef logic [CONFLICT_W-1:0] conflict_t;

    localparam conflict_t CONFLICT_MAX = '1;

    // True when two or more bits of the (zero-extended) request vector are set.
    function automatic logic multi_hot(input logic [MAX_PORTS-1:0] v);
        return (v & (v - MAX_PORTS'(1))) != '0;
    endfunction

endpackage

// File: rtl/regex_cpu_memory_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester after last_grant wins.
module regex_cpu_memory_arbiter_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant,
    output logic            grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!grant_valid && req[ID_W'((int'(last_grant) + k) % N)]) begin
                grant[ID_W'((int'(last_grant) + k) % N)] = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regex_cpu_memory_arbiter.sv
// Arbitrates CPU_COUNT regex_cpu fetch ports onto one shared instruction BRAM read port.
module regex_cpu_memory_arbiter
    import regex_cpu_memory_arbiter_pkg::*;
#(
    parameter int CPU_COUNT         = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CPU_COUNT-1:0]                   memory_valid,
    input  logic [CPU_COUNT*MEMORY_ADDR_WIDTH-1:0] memory_addr,
    output logic [CPU_COUNT-1:0]                   memory_ready,
    output logic [CPU_COUNT*MEMORY_WIDTH-1:0]      memory_data,
    output logic                                   bram_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]           bram_addr,
    input  logic [MEMORY_WIDTH-1:0]                bram_rdata,
    output logic [31:0]                            conflict_count,
    input  logic                                   conflict_clear
);

    localparam int CPU_ID_BITS = $clog2(CPU_COUNT);

    logic [CPU_COUNT-1:0]         eligible_p0;
    logic [CPU_COUNT-1:0]         grant_p0;
    logic                         grant_vld_p0;
    logic [CPU_ID_BITS-1:0]       grant_idx_p0;
    logic [MEMORY_ADDR_WIDTH-1:0] grant_addr_p0;
    logic [MAX_PORTS-1:0]         eligible_ext;
    logic [CPU_ID_BITS-1:0]       last_grant;
    logic [CPU_COUNT-1:0]         rdata_vld_p2;
    logic [MEMORY_WIDTH-1:0]      hold_p2 [CPU_COUNT];
    conflict_t                    conflict_q;

    // Stage p0: a port that is being served this cycle may not be picked again.
    assign eligible_p0 = memory_valid & ~memory_ready;

    regex_cpu_memory_arbiter_rr_arbiter #(
        .N    (CPU_COUNT),
        .ID_W (CPU_ID_BITS)
    ) u_rr_arbiter (
        .req         (eligible_p0),
        .last_grant  (last_grant),
        .grant       (grant_p0),
        .grant_valid (grant_vld_p0)
    );

    always_comb begin
        grant_idx_p0  = '0;
        grant_addr_p0 = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            if (grant_p0[i]) begin
                grant_idx_p0  = CPU_ID_BITS'(i);
                grant_addr_p0 = memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        eligible_ext                = '0;
        eligible_ext[CPU_COUNT-1:0] = eligible_p0;
    end

    // Stage p1: registered grant drives the BRAM read and the ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memory_ready <= '0;
            bram_en      <= 1'b0;
            bram_addr    <= '0;
            last_grant   <= CPU_ID_BITS'(CPU_COUNT - 1);
            rdata_vld_p2 <= '0;
        end else begin
            memory_ready <= grant_p0;
            bram_en      <= grant_vld_p0;
            if (grant_vld_p0) begin
                bram_addr  <= grant_addr_p0;
                last_grant <= grant_idx_p0;
            end
            rdata_vld_p2 <= memory_ready;
        end
    end

    // Stage p2: BRAM word is passed straight through, then held per port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CPU_COUNT; i++) begin
                hold_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CPU_COUNT; i++) begin
                if (rdata_vld_p2[i]) begin
                    hold_p2[i] <= bram_rdata;
                end
            end
        end
    end

    always_comb begin
        memory_data = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] = rdata_vld_p2[i] ? bram_rdata : hold_p2[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (conflict_clear) begin
            conflict_q <= '0;
        end else if (multi_hot(eligible_ext) && conflict_q != CONFLICT_MAX) begin
            conflict_q <= conflict_q + conflict_t'(1);
        end
    end

    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_regex_cpu_memory_arbiter.sv
// Scoreboard bench for regex_cpu_memory_arbiter with a behavioural BRAM and CPU port models.
module tb_regex_cpu_memory_arbiter;

    localparam int N  = 4;
    localparam int MW = 16;
    localparam int AW = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      memory_valid = '0;
    logic [N*AW-1:0]   memory_addr = '0;
    logic [N-1:0]      memory_ready;
    logic [N*MW-1:0]   memory_data;
    logic              bram_en;
    logic [AW-1:0]     bram_addr;
    logic [MW-1:0]     bram_rdata = '0;
    logic [31:0]       conflict_count;
    logic              conflict_clear = 1'b0;

    always #5 clk = ~clk;

    regex_cpu_memory_arbiter #(
        .CPU_COUNT         (N),
        .MEMORY_WIDTH      (MW),
        .MEMORY_ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .memory_valid   (memory_valid),
        .memory_addr    (memory_addr),
        .memory_ready   (memory_ready),
        .memory_data    (memory_data),
        .bram_en        (bram_en),
        .bram_addr      (bram_addr),
        .bram_rdata     (bram_rdata),
        .conflict_count (conflict_count),
        .conflict_clear (conflict_clear)
    );

    function automatic logic [MW-1:0] word_at(input logic [AW-1:0] a);
        if (a == 11'h05A) return 16'hBEEF;
        return {a[4:0], a} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) begin
        if (bram_en) bram_rdata <= word_at(bram_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [AW-1:0] exp_q [N][$];
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  hold_req = '0;
    logic [AW-1:0] pend_addr [N];
    logic [MW-1:0] last_word [N];
    int            wait_cnt [N];
    logic [31:0]   cc_model = '0;

    task automatic request(input int i, input logic [AW-1:0] a);
        memory_valid[i] = 1'b1;
        memory_addr[i*AW +: AW] = a;
        exp_q[i].push_back(a);
    endtask

    task automatic reset_model();
        memory_valid   = '0;
        hold_req       = '0;
        pend           = '0;
        conflict_clear = 1'b0;
        cc_model       = '0;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            last_word[i] = '0;
            wait_cnt[i]  = 0;
        end
    endtask

    task automatic stop_all();
        memory_valid = '0;
        hold_req     = '0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    task automatic monitor();
        logic [AW-1:0] a;
        check("bram_en", {31'd0, bram_en}, {31'd0, |memory_ready});
        check("ready_onehot", {31'd0, $onehot0(memory_ready)}, 32'd1);
        check("conflict_count", conflict_count, cc_model);
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                check($sformatf("data%0d", i), {16'd0, memory_data[i*MW +: MW]}, {16'd0, word_at(pend_addr[i])});
                last_word[i] = word_at(pend_addr[i]);
                pend[i] = 1'b0;
            end else begin
                check($sformatf("hold%0d", i), {16'd0, memory_data[i*MW +: MW]}, {16'd0, last_word[i]});
            end
            if (memory_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("ready_unexpected%0d", i), {31'd0, memory_ready[i]}, 32'd0);
                end else begin
                    a = exp_q[i].pop_front();
                    check($sformatf("bram_addr%0d", i), {21'd0, bram_addr}, {21'd0, a});
                    check($sformatf("wait%0d", i), {31'd0, wait_cnt[i] <= N}, 32'd1);
                    pend[i] = 1'b1;
                    pend_addr[i] = a;
                    wait_cnt[i] = 0;
                    if (hold_req[i]) begin
                        request(i, a);
                    end else begin
                        memory_valid[i] = 1'b0;
                        memory_addr[i*AW +: AW] = AW'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] elig;
        elig = memory_valid & ~memory_ready;
        for (int i = 0; i < N; i++) if (elig[i]) wait_cnt[i]++;
        if (rst || conflict_clear) cc_model = '0;
        else if ($countones(elig) >= 2 && cc_model != 32'hFFFF_FFFF) cc_model++;
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        reset_model();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        logic prev;
        logic seen;
        reset_model();
        repeat (3) cycle();
        check("reset_ready", {28'd0, memory_ready}, 32'd0);
        check("reset_bram_addr", {21'd0, bram_addr}, 32'd0);
        rst = 1'b0;

        // Single request on port 2
        request(2, 11'h05A);
        cycle();
        check("single_ready", {28'd0, memory_ready}, 32'h4);
        check("single_addr", {21'd0, bram_addr}, 32'h05A);
        cycle();
        check("single_data", {16'd0, memory_data[2*MW +: MW]}, 32'hBEEF);
        repeat (3) cycle();
        check("single_held", {16'd0, memory_data[2*MW +: MW]}, 32'hBEEF);

        // All four ports together from reset
        do_reset();
        for (int i = 0; i < N; i++) request(i, AW'(11'h100 + i));
        for (int g = 0; g < N; g++) begin
            cycle();
            check($sformatf("order%0d", g), {28'd0, memory_ready}, 32'd1 << g);
        end
        repeat (2) cycle();
        check("order_conflicts", conflict_count, 32'd3);

        // Port 1 requesting continuously alone
        hold_req[1] = 1'b1;
        request(1, 11'h123);
        pulses = 0;
        prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            check("no_back_to_back", {31'd0, memory_ready[1] & prev}, 32'd0);
            prev = memory_ready[1];
            if (memory_ready[1]) pulses++;
        end
        check("alt_pulses", pulses, 32'd6);
        stop_all();
        repeat (3) cycle();

        // Reset right after ready[0]
        request(0, 11'h010);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            cycle();
            seen = memory_ready[0];
        end
        check("rst_wait_ready0", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        reset_model();
        check("rst_data0", {16'd0, memory_data[0 +: MW]}, 32'd0);
        repeat (2) cycle();
        check("rst_data0_stays", {16'd0, memory_data[0 +: MW]}, 32'd0);
        rst = 1'b0;
        request(0, 11'h020);
        request(1, 11'h021);
        cycle();
        check("rst_first_grant", {28'd0, memory_ready}, 32'h1);
        repeat (4) cycle();

        // Saturation and clear of conflict_count
        dut.conflict_q = 32'hFFFF_FFFC;
        cc_model = 32'hFFFF_FFFC;
        hold_req = '1;
        for (int i = 0; i < N; i++) request(i, AW'(11'h200 + 3 * i));
        repeat (8) cycle();
        check("conflict_saturated", conflict_count, 32'hFFFF_FFFF);
        conflict_clear = 1'b1;
        cycle();
        conflict_clear = 1'b0;
        check("conflict_cleared", conflict_count, 32'd0);
        cycle();
        stop_all();
        repeat (4) cycle();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (!memory_valid[i] && $urandom_range(0, 2) == 0)
                    request(i, AW'($urandom_range(0, 2047)));
            end
        end
        stop_all();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
